serial_sub_ctrl: RTL



---
 rtl/serial_sub_ctrl_pkg.sv | 16 +
 rtl/serial_sub_ctrl_if.sv | 39 +++
 rtl/serial_sub_ctrl_full_sub_bit.sv | 13 +
 rtl/serial_sub_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count processed bit positions 0..w-1 (w >= 2).
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for serial_sub_ctrl.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             borrow_out;
  logic             busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  // Subtractor side.
  modport slave (
    input  start, a, b, borrow_in, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, d, borrow_out, busy
  );

  // Requester / consumer side.
  modport master (
    output start, a, b, borrow_in, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, d, borrow_out, busy
  );

endinterface

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: D = A - B - borrow_in, one bit per
// clock, LSB first, through a single full_sub_bit cell.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds signed-overflow output).
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_sub_ctrl_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic             r_borrow_out;
  logic             w_bit;
  logic             w_bout;
  logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  full_sub_bit u_bit (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_bin  (r_borrow),
    .o_d    (w_bit),
    .o_bout (w_bout)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  // NOTE: the default assignment at the top keeps this purely combinational;
  // leaving a path unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (bus.start)     w_next_state = RUN;
      RUN:     if (w_last)        w_next_state = DONE;
      DONE:    if (bus.out_ready) w_next_state = IDLE;
      default:                    w_next_state = IDLE;
    endcase
  end

  // Status outputs decoded from state, result registers driven out.
  always_comb begin
    bus.in_ready   = (r_state == IDLE);
    bus.busy       = (r_state == RUN);
    bus.out_valid  = (r_state == DONE);
    bus.d          = r_d;
    bus.borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    bus.ovf        = r_ovf;
`endif
  end

  // Datapath: operand load, per-bit subtract/shift, final borrow capture.
  // NOTE: the result and flag registers are reset because their reset value
  // is visible on the outputs; the operand shift registers are reset too so
  // an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_d          <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_ovf        <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sr   <= bus.a;
            r_b_sr   <= bus.b;
            r_borrow <= bus.borrow_in;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_d      <= {w_bit, r_d[WIDTH-1:1]};
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_borrow_out <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
            // The bit produced now is the result MSB.
            r_ovf        <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_bit);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
